move_pattern_gen: RTL and testbench

Parametrised successor to the button-stepped probe movement generator. Each debounced button press advances a position index through `N_POS` points along a configurable diagonal. The block drives signed X/Y offsets for that point into the sensor positioning path, and can optionally slew to each new point instead of jumping. It sits between the front-panel button and the X/Y offset summing stage.

---
 rtl/move_pattern_gen.sv | 144 ++++++++++++++
 tb/tb_move_pattern_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_pattern_gen.sv
// Button-stepped diagonal position generator: debounced presses walk idx through N_POS points.
// Define MOVE_GEN_RAMP_EN to slew MOVE_X/MOVE_Y toward each new point instead of jumping.
module move_pattern_gen #(
  parameter int WIDTH     = 32,
  parameter int N_POS     = 3,
  parameter int STEP_X    = -512,
  parameter int STEP_Y    = 512,
  parameter int DEBOUNCE  = 16,
  parameter int RAMP_RATE = 64,
  parameter int RAMP_DIV  = 1,
  localparam int IW       = (N_POS > 1) ? $clog2(N_POS) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    button,
  input  logic                    clear,
  output logic [IW-1:0]           idx,
  output logic signed [WIDTH-1:0] MOVE_X,
  output logic signed [WIDTH-1:0] MOVE_Y,
  output logic                    busy,
  output logic                    settled
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_POS - 1);
  localparam logic signed [WIDTH-1:0] STEP_XW = WIDTH'(STEP_X);
  localparam logic signed [WIDTH-1:0] STEP_YW = WIDTH'(STEP_Y);

  if (N_POS < 2 || DEBOUNCE < 1 || RAMP_RATE < 1 || RAMP_DIV < 1) begin : g_bad_cfg
    $error("move_pattern_gen: invalid parameter set");
  end

  logic                    btn_meta_reg, btn_s_reg;
  logic                    db_reg, db_next, rise;
  logic [DW-1:0]           db_cnt_reg, db_cnt_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic signed [WIDTH-1:0] idx_w;
  logic signed [WIDTH-1:0] tx_reg, ty_reg, tx_next, ty_next;
  logic signed [WIDTH-1:0] mx_reg, my_reg, mx_next, my_next;
  logic                    settled_reg, settled_next;

  always_comb begin
    db_next     = db_reg;
    db_cnt_next = '0;
    rise        = 1'b0;
    if (btn_s_reg != db_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        db_next = btn_s_reg;
        rise    = btn_s_reg;
      end else begin
        db_cnt_next = db_cnt_reg + 1'b1;
      end
    end

    idx_next = idx_reg;
    if (clear)
      idx_next = '0;
    else if (rise)
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

    idx_w   = WIDTH'(idx_next);
    tx_next = idx_w * STEP_XW;
    ty_next = idx_w * STEP_YW;
  end

`ifdef MOVE_GEN_RAMP_EN
  localparam int VW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [VW-1:0] DIV_LAST = VW'(RAMP_DIV - 1);
  localparam logic signed [WIDTH-1:0] RATE_W = WIDTH'(RAMP_RATE);

  logic [VW-1:0] div_reg, div_next;

  // Moves cur toward tgt by at most RATE_W; the span never exceeds half the signed range.
  function automatic logic signed [WIDTH-1:0] slew(input logic signed [WIDTH-1:0] cur,
                                                   input logic signed [WIDTH-1:0] tgt);
    logic signed [WIDTH-1:0] diff;
    diff = tgt - cur;
    if (diff > RATE_W)
      return cur + RATE_W;
    else if (diff < -RATE_W)
      return cur - RATE_W;
    else
      return tgt;
  endfunction

  always_comb begin
    div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    mx_next  = mx_reg;
    my_next  = my_reg;
    if (div_reg == '0) begin
      mx_next = slew(mx_reg, tx_reg);
      my_next = slew(my_reg, ty_reg);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      div_reg <= '0;
    else
      div_reg <= div_next;
  end
`else
  always_comb begin
    mx_next = tx_reg;
    my_next = ty_reg;
  end
`endif

  assign busy         = (mx_reg != tx_reg) | (my_reg != ty_reg);
  assign settled_next = busy & (mx_next == tx_next) & (my_next == ty_next);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_reg <= 1'b0;
      btn_s_reg    <= 1'b0;
      db_reg       <= 1'b0;
      db_cnt_reg   <= '0;
      idx_reg      <= '0;
      tx_reg       <= '0;
      ty_reg       <= '0;
      mx_reg       <= '0;
      my_reg       <= '0;
      settled_reg  <= 1'b0;
    end else begin
      btn_meta_reg <= button;
      btn_s_reg    <= btn_meta_reg;
      db_reg       <= db_next;
      db_cnt_reg   <= db_cnt_next;
      idx_reg      <= idx_next;
      tx_reg       <= tx_next;
      ty_reg       <= ty_next;
      mx_reg       <= mx_next;
      my_reg       <= my_next;
      settled_reg  <= settled_next;
    end
  end

  assign idx     = idx_reg;
  assign MOVE_X  = mx_reg;
  assign MOVE_Y  = my_reg;
  assign settled = settled_reg;

endmodule

// File: tb/tb_move_pattern_gen.sv
// Self-checking bench for move_pattern_gen: directed steps plus random button/clear traffic
// compared every cycle against a behavioural model of the press/position/slew rules.
module tb_move_pattern_gen;

  localparam int WIDTH     = 32;
  localparam int N_POS     = 3;
  localparam int STEP_X    = -512;
  localparam int STEP_Y    = 512;
  localparam int DEBOUNCE  = 4;
  localparam int RAMP_RATE = 256;
  localparam int RAMP_DIV  = 1;
  localparam int IW        = $clog2(N_POS);

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    button = 1'b0;
  logic                    clear = 1'b0;
  logic [IW-1:0]           idx;
  logic signed [WIDTH-1:0] MOVE_X, MOVE_Y;
  logic                    busy, settled;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_s1, m_s2, m_db, m_run, m_idx, m_tx, m_ty, m_mx, m_my, m_div, m_settled;

  move_pattern_gen #(
    .WIDTH(WIDTH), .N_POS(N_POS), .STEP_X(STEP_X), .STEP_Y(STEP_Y),
    .DEBOUNCE(DEBOUNCE), .RAMP_RATE(RAMP_RATE), .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clock(clock), .reset_n(reset_n), .button(button), .clear(clear),
    .idx(idx), .MOVE_X(MOVE_X), .MOVE_Y(MOVE_Y), .busy(busy), .settled(settled)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_idx = 0;
    m_tx = 0; m_ty = 0; m_mx = 0; m_my = 0; m_div = 0; m_settled = 0;
  endtask

  function automatic int approach(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d > RAMP_RATE) return cur + RAMP_RATE;
    if (d < -RAMP_RATE) return cur - RAMP_RATE;
    return tgt;
  endfunction

  // One rising edge of the reference: press detection from the synchronised button history,
  // index/target update, then outputs chase the targets that were in place before the edge.
  task automatic model_edge();
    int old_tx, old_ty, rise;
    bit was_busy, now_busy;
    if (!reset_n) begin
      model_reset();
      return;
    end
    was_busy = (m_mx != m_tx) || (m_my != m_ty);
    old_tx = m_tx;
    old_ty = m_ty;
    rise = 0;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_db = m_s2;
        m_run = 0;
        rise = m_db;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(button);
`ifdef MOVE_GEN_RAMP_EN
    if (m_div == 0) begin
      m_mx = approach(m_mx, old_tx);
      m_my = approach(m_my, old_ty);
    end
    m_div = (m_div + 1) % RAMP_DIV;
`else
    m_mx = old_tx;
    m_my = old_ty;
`endif
    if (clear) m_idx = 0;
    else if (rise != 0) m_idx = (m_idx + 1) % N_POS;
    m_tx = m_idx * STEP_X;
    m_ty = m_idx * STEP_Y;
    now_busy = (m_mx != m_tx) || (m_my != m_ty);
    m_settled = int'(was_busy && !now_busy);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".idx"}, int'(idx), m_idx);
    check({tag, ".mx"}, int'(MOVE_X), m_mx);
    check({tag, ".my"}, int'(MOVE_Y), m_my);
    check({tag, ".busy"}, int'(busy), int'((m_mx != m_tx) || (m_my != m_ty)));
    check({tag, ".settled"}, int'(settled), m_settled);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_model("cyc");
    end
  endtask

  task automatic press(input int exp_idx);
    button = 1'b1;
    step(DEBOUNCE + 2);
    check("press.idx", int'(idx), exp_idx);
    step(2);
    button = 1'b0;
    step(2 * DEBOUNCE);
  endtask

  initial begin
    int len;
    model_reset();
    #1;
    check("rst.idx", int'(idx), 0);
    check("rst.mx", int'(MOVE_X), 0);
    check("rst.my", int'(MOVE_Y), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.settled", int'(settled), 0);
    step(2);
    reset_n = 1'b1;
    step(2);

    // Single press held 20 cycles; edge numbering starts at the next rising edge
    button = 1'b1;
    step(5);
    check("single.pre_idx", int'(idx), 0);
    step(1);
    check("single.e6_idx", int'(idx), 1);
    check("single.e6_busy", int'(busy), 1);
    check("single.e6_mx", int'(MOVE_X), 0);
    step(1);
`ifdef MOVE_GEN_RAMP_EN
    check("single.e7_mx", int'(MOVE_X), -256);
    check("single.e7_my", int'(MOVE_Y), 256);
    check("single.e7_busy", int'(busy), 1);
    step(1);
`endif
    check("single.final_mx", int'(MOVE_X), -512);
    check("single.final_my", int'(MOVE_Y), 512);
    check("single.final_busy", int'(busy), 0);
    check("single.settled", int'(settled), 1);
    step(1);
    check("single.settled_drop", int'(settled), 0);
    step(11);
    check("single.one_advance", int'(idx), 1);
    button = 1'b0;
    step(10);
    check("single.release", int'(idx), 1);

    // Glitch shorter than the debounce window
    button = 1'b1;
    step(3);
    button = 1'b0;
    step(10);
    check("glitch.idx", int'(idx), 1);
    check("glitch.mx", int'(MOVE_X), -512);

    // Clear back to the origin
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear.idx", int'(idx), 0);
    step(5);

    // Wrap: 1, 2, then back to 0 with a slew from the far corner
    press(1);
    press(2);
    step(4);
    check("wrap.corner_mx", int'(MOVE_X), -1024);
    button = 1'b1;
    step(DEBOUNCE + 2);
    check("wrap.idx", int'(idx), 0);
`ifdef MOVE_GEN_RAMP_EN
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("wrap.ramp_mx", int'(MOVE_X), -1024 + 256 * k);
      check("wrap.ramp_my", int'(MOVE_Y), 1024 - 256 * k);
    end
`else
    step(1);
    check("wrap.jump_mx", int'(MOVE_X), 0);
`endif
    check("wrap.settled", int'(settled), 1);
    step(2);
    button = 1'b0;
    step(2 * DEBOUNCE);

    // Clear on the same edge as an advance
    button = 1'b1;
    step(DEBOUNCE + 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_wins.idx", int'(idx), 0);
    step(2);
    button = 1'b0;
    step(2 * DEBOUNCE);

    // Retarget while a slew is in flight (clear starts a long slew, press lands mid-way)
    press(1);
    press(2);
    step(6);
    button = 1'b1;
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(6);
    button = 1'b0;
    step(2 * DEBOUNCE);

    // Asynchronous reset in the middle of a slew
    button = 1'b1;
    step(DEBOUNCE + 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst.idx", int'(idx), 0);
    check("async_rst.mx", int'(MOVE_X), 0);
    check("async_rst.my", int'(MOVE_Y), 0);
    check("async_rst.busy", int'(busy), 0);
    check("async_rst.settled", int'(settled), 0);
    model_reset();
    button = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);

    // Random button segments with occasional clears
    for (int seg = 0; seg < 40; seg++) begin
      button = ~button;
      len = int'($urandom_range(1, 12));
      for (int c = 0; c < len; c++) begin
        clear = ($urandom_range(0, 31) == 0);
        step(1);
      end
    end
    clear = 1'b0;
    button = 1'b0;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
